// File: rtl/bitonic_pkg.sv
// ============================================================================
// Module      : bitonic_pkg
// Description : Shared constants, layer table and state encoding for the
//               sequential 8-entry bitonic sorter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bitonic_pkg;

    localparam int N_ENTRIES = 8;
    localparam int N_LAYERS  = 6;
    localparam int PTR_W     = 3;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SORT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Per-layer (k, j): k selects the direction block size, j the partner distance.
    localparam logic [3:0] C_LAYER_K [N_LAYERS] = '{4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd8};
    localparam logic [2:0] C_LAYER_J [N_LAYERS] = '{3'd1, 3'd2, 3'd1, 3'd4, 3'd2, 3'd1};

    // q-th index with bit j clear: insert a zero at the bit position of j.
    function automatic logic [2:0] pair_lo(input logic [1:0] q, input logic [2:0] j);
        case (j)
            3'd1:    pair_lo = {q, 1'b0};
            3'd2:    pair_lo = {q[1], 1'b0, q[0]};
            default: pair_lo = {1'b0, q};
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/bitonic_cas.sv
// ============================================================================
// Module      : bitonic_cas
// Description : Unsigned compare-and-swap; equal values pass through unswapped.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitonic_cas #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              desc,
    output logic [DATA_W-1:0] out_i,
    output logic [DATA_W-1:0] out_p
);

    logic w_swap;

    assign w_swap = desc ? (a < b) : (a > b);
    assign out_i  = w_swap ? b : a;
    assign out_p  = w_swap ? a : b;

endmodule

`default_nettype wire

// File: rtl/bitonic_sort_ctrl.sv
// ============================================================================
// Module      : bitonic_sort_ctrl
// Description : Serial-in/serial-out 8-entry bitonic sorter reusing one layer
//               of four compare-and-swap units over six clocked layers.
//               Define BITONIC_SORT_DESCEND_EN for largest-first output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitonic_sort_ctrl
    import bitonic_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_entry [N_ENTRIES];
    logic [DATA_W-1:0] w_sorted [N_ENTRIES];
    logic [PTR_W-1:0]  r_ptr;
    logic [2:0]        r_layer;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_last_layer;
    logic [3:0]        w_k;
    logic [2:0]        w_j;

    logic [2:0]        w_lo_idx [4];
    logic [2:0]        w_hi_idx [4];
    logic [DATA_W-1:0] w_cas_i  [4];
    logic [DATA_W-1:0] w_cas_p  [4];

    assign w_in_fire    = in_valid & in_ready;
    assign w_out_fire   = out_valid & out_ready;
    assign w_last_layer = (r_layer == 3'(N_LAYERS - 1));
    assign w_k          = C_LAYER_K[r_layer];
    assign w_j          = C_LAYER_J[r_layer];

    genvar q;
    generate
        for (q = 0; q < 4; q++) begin : g_cas
            logic w_desc;

            assign w_lo_idx[q] = pair_lo(2'(q), w_j);
            assign w_hi_idx[q] = w_lo_idx[q] | w_j;
`ifdef BITONIC_SORT_DESCEND_EN
            assign w_desc = (({1'b0, w_lo_idx[q]} & w_k) == 4'd0);
`else
            assign w_desc = (({1'b0, w_lo_idx[q]} & w_k) != 4'd0);
`endif

            bitonic_cas #(.DATA_W(DATA_W)) u_cas (
                .a     (r_entry[w_lo_idx[q]]),
                .b     (r_entry[w_hi_idx[q]]),
                .desc  (w_desc),
                .out_i (w_cas_i[q]),
                .out_p (w_cas_p[q])
            );
        end
    endgenerate

    // Each layer touches every entry exactly once, so the pair writes never overlap.
    always_comb begin
        for (int e = 0; e < N_ENTRIES; e++) begin
            w_sorted[e] = r_entry[e];
        end
        for (int p = 0; p < 4; p++) begin
            w_sorted[w_lo_idx[p]] = w_cas_i[p];
            w_sorted[w_hi_idx[p]] = w_cas_p[p];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD: if (w_in_fire && r_ptr == 3'd7)  w_state_next = ST_SORT;
            ST_SORT: if (w_last_layer)                 w_state_next = ST_OUT;
            ST_OUT:  if (w_out_fire && r_ptr == 3'd7)  w_state_next = ST_LOAD;
            default:                                   w_state_next = ST_LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_LOAD);
        out_valid = (r_state == ST_OUT);
        out_last  = (r_state == ST_OUT) && (r_ptr == 3'd7);
        busy      = (r_state == ST_SORT) || (r_state == ST_OUT);
        out_data  = (r_state == ST_OUT) ? r_entry[r_ptr] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_layer <= '0;
            for (int e = 0; e < N_ENTRIES; e++) begin
                r_entry[e] <= '0;
            end
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_in_fire) begin
                        r_entry[r_ptr] <= in_data;
                        r_ptr          <= (r_ptr == 3'd7) ? 3'd0 : r_ptr + 3'd1;
                        if (r_ptr == 3'd7) begin
                            r_layer <= '0;
                        end
                    end
                end
                ST_SORT: begin
                    for (int e = 0; e < N_ENTRIES; e++) begin
                        r_entry[e] <= w_sorted[e];
                    end
                    r_layer <= w_last_layer ? 3'd0 : r_layer + 3'd1;
                    if (w_last_layer) begin
                        r_ptr <= '0;
                    end
                end
                ST_OUT: begin
                    if (w_out_fire) begin
                        r_ptr <= (r_ptr == 3'd7) ? 3'd0 : r_ptr + 3'd1;
                    end
                end
                default: begin
                    r_ptr   <= '0;
                    r_layer <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bitonic_sort_ctrl.sv
// ============================================================================
// Module      : tb_bitonic_sort_ctrl
// Description : Directed scoreboard bench for bitonic_sort_ctrl; expected
//               output order follows BITONIC_SORT_DESCEND_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bitonic_sort_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       out_last;
    logic       busy;

    int         n_checks;
    int         n_fail;
    logic [7:0] exp_q [$];
    logic [7:0] blk   [8];

    bitonic_sort_ctrl #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain insertion sort, independent of the bitonic network.
    task automatic push_expected(input logic [7:0] v [8]);
        logic [7:0] s [8];
        logic [7:0] t;
        int         j;
        s = v;
        for (int i = 1; i < 8; i++) begin
            t = s[i];
            j = i - 1;
            while (j >= 0 && s[j] > t) begin
                s[j + 1] = s[j];
                j--;
            end
            s[j + 1] = t;
        end
`ifdef BITONIC_SORT_DESCEND_EN
        for (int i = 7; i >= 0; i--) exp_q.push_back(s[i]);
`else
        for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
`endif
    endtask

    // Called and returns on a negedge; the last handshake is the preceding posedge.
    task automatic load_block(input logic [7:0] v [8], input int gap, input bit push);
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                @(negedge clk);
                check("in_ready_gap", 32'(in_ready), 32'd1);
            end
            in_valid = 1'b1;
            in_data  = v[i];
            check("in_ready_load", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (push) push_expected(v);
    endtask

    task automatic check_latency();
        int cycles;
        cycles = 0;
        check("busy_sort", 32'(busy), 32'd1);
        check("in_ready_sort", 32'(in_ready), 32'd0);
        while (!out_valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        check("latency", 32'(cycles), 32'd6);
    endtask

    task automatic drain(input int stall_beat, input int stall_cycles);
        logic [7:0] hold;
        logic [7:0] exp;
        int         w;
        for (int b = 0; b < 8; b++) begin
            w = 0;
            while (!out_valid && w < 40) begin
                @(negedge clk);
                w++;
            end
            check("out_valid", 32'(out_valid), 32'd1);
            if (b == stall_beat) begin
                out_ready = 1'b0;
                hold      = out_data;
                for (int s = 0; s < stall_cycles; s++) begin
                    @(negedge clk);
                    check("stall_data", 32'(out_data), 32'(hold));
                    check("stall_busy", 32'(busy), 32'd1);
                end
            end
            out_ready = 1'b1;
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
                exp = 8'hxx;
            end else begin
                exp = exp_q.pop_front();
            end
            check("out_data", 32'(out_data), 32'(exp));
            check("out_last", 32'(out_last), (b == 7) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
        check("post_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        blk = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load_block(blk, 0, 1'b1);
        check_latency();
        drain(-1, 0);

        blk = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
        load_block(blk, 0, 1'b1);
        check_latency();
        drain(-1, 0);

        blk = '{8'd3, 8'd200, 8'd0, 8'd255, 8'd17, 8'd17, 8'd90, 8'd1};
        load_block(blk, 2, 1'b1);
        check_latency();
        drain(3, 3);

        // Abort a block while layer 3 is about to be applied.
        blk = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load_block(blk, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("mid_sort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        blk = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load_block(blk, 0, 1'b1);
        check_latency();
        drain(-1, 0);

        blk = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load_block(blk, 1, 1'b1);
        check_latency();
        drain(6, 2);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bitonic_sort_ctrl.md
# bitonic_sort_ctrl

Sequential controller that time-multiplexes one layer of four compare-and-swap units to sort 8-entry blocks with the full bitonic network. Values stream in serially over a valid/ready handshake, are sorted in 6 clocked layers, then stream out serially. It sits between a byte-stream producer and consumer and replaces the combinational multi-stage sorter when area matters more than latency.

## Interface
- DATA_W, 8, width of each sorted value (unsigned)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a value on in_data
- in_data  input  DATA_W  value to load
- in_ready  output  1  block accepts a value this cycle
- out_valid  output  1  out_data holds a sorted value
- out_data  output  DATA_W  sorted value, smallest first (default build)
- out_ready  input  1  consumer accepts out_data this cycle
- out_last  output  1  marks the 8th output beat of a block
- busy  output  1  high in SORT and OUT states

## Operation
- Register file: eight DATA_W entries, index 0..7; 3-bit load/output pointer; 3-bit layer counter.
- FSM states: LOAD, SORT, OUT.
- LOAD: in_ready=1. On in_valid&in_ready, write in_data to entry[ptr], ptr++. On the 8th accepted beat (ptr==7), ptr←0, layer←0, go to SORT.
- SORT: in_ready=0, out_valid=0. Each cycle applies one layer to all 8 entries, layer++. After layer 5, ptr←0, go to OUT.
- Layer table (k, j): 0:(2,1) 1:(4,2) 2:(4,1) 3:(8,4) 4:(8,2) 5:(8,1). For each i with (i & j)==0, partner p=i|j; ascending when (i & k)==0, else descending. Ascending puts min at i, max at p.
- Comparison is unsigned; equal values are not swapped.
- OUT: out_valid=1, out_data=entry[ptr], out_last=(ptr==7). On out_valid&out_ready, ptr++. On the last handshake, ptr←0, go to LOAD.
- No overlap: a new block cannot load until the previous block has drained.

## Timing
- Reset values: state=LOAD, ptr=0, layer=0, entries=0, in_ready=1 (combinational from state), out_valid=0, out_data=0, out_last=0, busy=0.
- Load: one beat per cycle max; gaps in in_valid are allowed and leave state unchanged.
- Latency: the 8th input handshake on edge t; SORT occupies edges t+1..t+6; out_valid rises after edge t+6, first output beat can complete on edge t+7.
- Back-pressure: while out_valid=1 and out_ready=0, out_data and out_last stay stable.
- Throughput: minimum 8+6+8=22 cycles per block.
- Reset mid-operation: any state aborts immediately to LOAD, partial data discarded, counters cleared.
- in_valid during SORT/OUT is ignored (in_ready=0); no data is lost because producer must hold.

## Configuration
- BITONIC_SORT_DESCEND_EN: when defined, every layer direction is inverted; output streams largest first. Undefined: ascending, smallest first. Latency and handshake identical.

## Structure
- bitonic_pkg: N_ENTRIES=8, N_LAYERS=6, layer k/j constant arrays, state enum typedef.
- One sub-module: bitonic_cas (two DATA_W inputs, direction bit, two outputs), instantiated four times; per-layer pairing is muxed in the controller.

## Test plan
- Load 8,7,6,5,4,3,2,1 -> outputs 1..8, out_last only on 8, first out_valid 6 cycles after last input handshake.
- Load 0x55 eight times -> eight 0x55 beats, no X, out_last on beat 8.
- Load 3,200,0,255,17,17,90,1 with in_valid gaps of 2 cycles -> outputs 0,1,3,17,17,90,200,255.
- Drop out_ready for 3 cycles at beat 4 -> out_data holds value stably, sequence unaltered, busy stays 1.
- Assert rst_n low during SORT layer 3 -> all outputs return to reset values, next block 1..8 sorts correctly.
- With BITONIC_SORT_DESCEND_EN, load 1..8 -> outputs 8..1.
